rf_writeback_queue: RTL and testbench
=====================================

// Module: rf_writeback_queue
// PURPOSE
//  Producer side of the integer register-file write port (we / write_addr / write_data).
//  Merges writebacks from two result sources (p0: in-order ALU/MEM-WB, p1: multi-cycle unit) into a FIFO.
//  Drains at most one entry per cycle into the register file.
//  Returns youngest pending data for two read addresses, so decode sees values not yet committed.
// PARAMETERS
//  XLEN   64  data width of a register
//  DEPTH  4   queue entries; legal range 2..16
// PORTS
//  clk          in   1     clock; all state updates on posedge
//  rst          in   1     reset, asynchronous, active-high
//  p0_valid     in   1     source-0 writeback request
//  p0_ready     out  1     source-0 may push this cycle
//  p0_addr      in   5     destination register, source 0
//  p0_data      in   XLEN  result, source 0
//  p1_valid     in   1     source-1 writeback request
//  p1_ready     out  1     source-1 may push this cycle
//  p1_addr      in   5     destination register, source 1
//  p1_data      in   XLEN  result, source 1
//  rf_hold      in   1     freeze draining (debug halt)
//  rf_we        out  1     register-file write enable
//  rf_addr      out  5     register-file write address
//  rf_data      out  XLEN  register-file write data
//  fwd_addr_1   in   5     lookup address, read port 1
//  fwd_hit_1    out  1     pending entry matches fwd_addr_1
//  fwd_data_1   out  XLEN  youngest matching data, port 1
//  fwd_addr_2   in   5     lookup address, read port 2
//  fwd_hit_2    out  1     pending entry matches fwd_addr_2
//  fwd_data_2   out  XLEN  youngest matching data, port 2
//  busy         out  1     queue non-empty
// BEHAVIOUR
//  State and pointers
//   - Circular FIFO: head ptr, tail ptr, count of width $clog2(DEPTH+1).
//   - Pointers wrap from DEPTH-1 to 0.
//  Write-port outputs (combinational from head)
//   - rf_we   = busy & ~rf_hold.
//   - rf_addr = head addr; rf_data = head data.
//   - The register file samples on negedge; the queue pops on the following posedge when rf_we=1.
//   - Write latency: a push at posedge N appears on rf_* during cycle N+1 (queue previously empty).
//  Ready rules (registered-count based, no valid->ready path)
//   - p0_ready = count <= DEPTH-1.
//   - p1_ready = count <= DEPTH-2.
//   - Pop credit is not used for ready.
//  Pushing and ordering
//   - Handshake occurs when valid & ready at posedge.
//   - When both handshake in one cycle, p0 is enqueued first (older), then p1.
//   - A push with addr==0 completes the handshake but is discarded (never enqueued, never forwarded).
//  Simultaneous push and pop
//   - count += pushes - pop.
//   - Full queue with pop: ready still deasserted that cycle (conservative).
//  Forwarding
//   - Scan valid entries youngest to oldest; hit on the first addr match with fwd_addr!=0.
//   - fwd_data = that entry's data.
//   - No hit: fwd_hit=0, fwd_data=0.
//   - Same-cycle incoming pushes are NOT visible.
//   - The head entry being written this cycle IS still visible until popped.
//  Reset
//   - Async rst clears count and pointers (contents don't care).
//   - While rst: rf_we=0, busy=0, fwd_hit_*=0, p0_ready=p1_ready=1 (DEPTH>=2).
//   - rst mid-operation drops all pending entries.
//  rf_hold
//   - No pops; pushes still accepted subject to ready.
// CONFIGURATION
//  RF_WBQ_FWD_EN defined
//   - Forwarding lookup is built as described.
//  RF_WBQ_FWD_EN undefined
//   - fwd_hit_1/2 tied 0, fwd_data_1/2 tied 0, no compare logic.
//   - Consumer must stall on busy.
// STRUCTURE
//  Shared package rf_pkg:
//   - REG_ADDR_W=5.
//   - Typedef wb_entry_t {addr[4:0], data[XLEN-1:0]}.
//   - Function is_x0(addr).
//  Sub-module rf_wbq_fwd_lookup:
//   - Youngest-first priority match over DEPTH entries.
//   - Instantiated twice, only under RF_WBQ_FWD_EN.
// TESTING
//  1. rst mid-queue
//     - rst with 3 entries queued -> rf_we=0 and busy=0 immediately (async).
//     - After release, no write to the dropped addresses occurs.
//  2. Single push
//     - p0 push x5=0x1234 at posedge 1 -> rf_we=1, rf_addr=5, rf_data=0x1234 in cycle 2.
//     - busy=0 in cycle 3.
//  3. Dual push
//     - Same cycle p0 x3=0xA, p1 x3=0xB -> rf writes x3=0xA then x3=0xB on consecutive cycles.
//     - fwd_addr_1=3 returns 0xB while both entries are pending.
//  4. x0 discard
//     - p0 push x0=0xFFFF -> p0_ready=1, handshake completes.
//     - No enqueue, busy stays 0, fwd_hit=0 for fwd_addr=0.
//  5. Backpressure
//     - rf_hold=1, push until full (DEPTH=4) -> p1_ready=0 at count 3, p0_ready=0 at count 4.
//     - Release hold -> 4 writes drain in push order.
//  6. Forwarding compiled out
//     - Build without RF_WBQ_FWD_EN -> fwd_hit_1/2 stay 0 with matching entries queued.
//     - Writes are unchanged.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file definitions for the writeback queue and its lookup sub-module.
package rf_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // x0 is hardwired to zero, so writes to it are dropped and it never forwards.
  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/rf_wbq_fwd_lookup.sv
// Youngest-first address match over the age-ordered queue entries.
// Index 0 is the oldest entry, index DEPTH-1 the youngest slot.
module rf_wbq_fwd_lookup
  import rf_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic [DEPTH-1:0]                 valid,
  input  logic [DEPTH-1:0][REG_ADDR_W-1:0] addr,
  input  logic [DEPTH-1:0][XLEN-1:0]       data,
  input  logic [REG_ADDR_W-1:0]            lookup_addr,
  output logic                             hit,
  output logic [XLEN-1:0]                  hit_data
);

  // Ascending scan: a later (younger) match overrides an older one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid[i] && (addr[i] == lookup_addr) && !is_x0(lookup_addr)) begin
        hit      = 1'b1;
        hit_data = data[i];
      end
    end
  end

endmodule

// File: rtl/rf_writeback_queue.sv
// Register-file writeback queue: merges two result sources into a FIFO that drains
// one entry per cycle into the register-file write port.
// Optional forwarding of pending values is built when RF_WBQ_FWD_EN is defined.
module rf_writeback_queue
  import rf_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic [REG_ADDR_W-1:0] p0_addr,
  input  logic [XLEN-1:0]       p0_data,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic [REG_ADDR_W-1:0] p1_addr,
  input  logic [XLEN-1:0]       p1_data,
  input  logic                  rf_hold,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic [XLEN-1:0]       rf_data,
  input  logic [REG_ADDR_W-1:0] fwd_addr_1,
  output logic                  fwd_hit_1,
  output logic [XLEN-1:0]       fwd_data_1,
  input  logic [REG_ADDR_W-1:0] fwd_addr_2,
  output logic                  fwd_hit_2,
  output logic [XLEN-1:0]       fwd_data_2,
  output logic                  busy
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] CntP0Max = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CntP1Max = CW'(DEPTH - 2);
  localparam logic [PW-1:0] PtrLast  = PW'(DEPTH - 1);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [REG_ADDR_W-1:0] addr_mem [DEPTH];
  logic [XLEN-1:0]       data_mem [DEPTH];

  logic          push0, push1, pop;
  logic          wr0_en, wr1_en;
  logic [PW-1:0] wr0_idx, wr1_idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PtrLast) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Ready depends only on the registered count; pop credit is deliberately ignored.
  always_comb begin
    p0_ready = (count_q <= CntP0Max);
    p1_ready = (count_q <= CntP1Max);
    busy     = (count_q != '0);
    rf_we    = busy & ~rf_hold;
    rf_addr  = addr_mem[head_q];
    rf_data  = data_mem[head_q];
  end

  // Handshake, enqueue slot selection and pointer/count next state.
  always_comb begin
    push0   = p0_valid & p0_ready & ~is_x0(p0_addr);
    push1   = p1_valid & p1_ready & ~is_x0(p1_addr);
    pop     = rf_we;
    wr0_en  = push0;
    wr0_idx = tail_q;
    wr1_en  = push1;
    // p0 is older, so p1 lands behind it when both are enqueued.
    wr1_idx = push0 ? ptr_inc(tail_q) : tail_q;
    tail_d  = tail_q;
    if (push0 && push1) begin
      tail_d = ptr_inc(ptr_inc(tail_q));
    end else if (push0 || push1) begin
      tail_d = ptr_inc(tail_q);
    end
    head_d  = pop ? ptr_inc(head_q) : head_q;
    count_d = count_q + CW'(push0) + CW'(push1) - CW'(pop);
  end

  // Pointer and count registers; reset drops every pending entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are don't-care after reset so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      addr_mem[wr0_idx] <= p0_addr;
      data_mem[wr0_idx] <= p0_data;
    end
    if (wr1_en) begin
      addr_mem[wr1_idx] <= p1_addr;
      data_mem[wr1_idx] <= p1_data;
    end
  end

`ifdef RF_WBQ_FWD_EN
  logic [DEPTH-1:0]                 ord_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ord_addr;
  logic [DEPTH-1:0][XLEN-1:0]       ord_data;

  // Rotate storage into age order starting at head; only the first count slots are live.
  always_comb begin
    ord_valid = '0;
    ord_addr  = '0;
    ord_data  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      int unsigned slot;
      slot         = (int'(head_q) + i) % DEPTH;
      ord_valid[i] = (i < int'(count_q));
      ord_addr[i]  = addr_mem[slot[PW-1:0]];
      ord_data[i]  = data_mem[slot[PW-1:0]];
    end
  end

  rf_wbq_fwd_lookup #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_lookup_1 (
    .valid       (ord_valid),
    .addr        (ord_addr),
    .data        (ord_data),
    .lookup_addr (fwd_addr_1),
    .hit         (fwd_hit_1),
    .hit_data    (fwd_data_1)
  );

  rf_wbq_fwd_lookup #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_lookup_2 (
    .valid       (ord_valid),
    .addr        (ord_addr),
    .data        (ord_data),
    .lookup_addr (fwd_addr_2),
    .hit         (fwd_hit_2),
    .hit_data    (fwd_data_2)
  );
`else
  // No forwarding: consumers stall on busy instead.
  logic unused_fwd;
  assign unused_fwd = ^{fwd_addr_1, fwd_addr_2};
  assign fwd_hit_1  = 1'b0;
  assign fwd_data_1 = '0;
  assign fwd_hit_2  = 1'b0;
  assign fwd_data_2 = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Self-checking bench for rf_writeback_queue (DEPTH=4): table-driven cycles with a
// scoreboard of expected register-file writes and forwarded values.
module tb_rf_writeback_queue;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            p0_valid, p1_valid, p0_ready, p1_ready;
  logic [4:0]      p0_addr, p1_addr;
  logic [XLEN-1:0] p0_data, p1_data;
  logic            rf_hold, rf_we, busy;
  logic [4:0]      rf_addr, fwd_addr_1, fwd_addr_2;
  logic [XLEN-1:0] rf_data, fwd_data_1, fwd_data_2;
  logic            fwd_hit_1, fwd_hit_2;

  int checks   = 0;
  int failures = 0;

  rf_writeback_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p0_valid   (p0_valid),
    .p0_ready   (p0_ready),
    .p0_addr    (p0_addr),
    .p0_data    (p0_data),
    .p1_valid   (p1_valid),
    .p1_ready   (p1_ready),
    .p1_addr    (p1_addr),
    .p1_data    (p1_data),
    .rf_hold    (rf_hold),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .fwd_addr_1 (fwd_addr_1),
    .fwd_hit_1  (fwd_hit_1),
    .fwd_data_1 (fwd_data_1),
    .fwd_addr_2 (fwd_addr_2),
    .fwd_hit_2  (fwd_hit_2),
    .fwd_data_2 (fwd_data_2),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            p0v;
    logic [4:0]      p0a;
    logic [XLEN-1:0] p0d;
    logic            p1v;
    logic [4:0]      p1a;
    logic [XLEN-1:0] p1d;
    logic            hold;
    logic [4:0]      fa1;
    logic [4:0]      fa2;
    logic            r0;
    logic            r1;
  } vec_t;

  typedef struct {
    logic [4:0]      a;
    logic [XLEN-1:0] d;
  } ent_t;

  ent_t mq[$];
  vec_t vecs[18];

  function automatic vec_t mk(logic p0v, logic [4:0] p0a, logic [XLEN-1:0] p0d,
                              logic p1v, logic [4:0] p1a, logic [XLEN-1:0] p1d,
                              logic hold, logic [4:0] fa1, logic [4:0] fa2,
                              logic r0, logic r1);
    vec_t v;
    v.p0v = p0v; v.p0a = p0a; v.p0d = p0d;
    v.p1v = p1v; v.p1a = p1a; v.p1d = p1d;
    v.hold = hold; v.fa1 = fa1; v.fa2 = fa2; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected forwarding result from the scoreboard contents (youngest first).
  task automatic fwd_exp(input logic [4:0] a, output logic hit, output logic [XLEN-1:0] d);
    hit = 1'b0;
    d   = '0;
`ifdef RF_WBQ_FWD_EN
    if (a != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].a == a) begin
          hit = 1'b1;
          d   = mq[i].d;
          break;
        end
      end
    end
`endif
  endtask

  task automatic step(input vec_t v, input string tag);
    logic            eh;
    logic [XLEN-1:0] ed;
    logic            exp_we, acc0, acc1;
    @(negedge clk);
    p0_valid = v.p0v; p0_addr = v.p0a; p0_data = v.p0d;
    p1_valid = v.p1v; p1_addr = v.p1a; p1_data = v.p1d;
    rf_hold = v.hold; fwd_addr_1 = v.fa1; fwd_addr_2 = v.fa2;
    #1;
    exp_we = (mq.size() > 0) && !v.hold;
    chk({tag, " p0_ready"}, XLEN'(p0_ready), XLEN'(v.r0));
    chk({tag, " p1_ready"}, XLEN'(p1_ready), XLEN'(v.r1));
    chk({tag, " busy"}, XLEN'(busy), XLEN'(mq.size() > 0));
    chk({tag, " rf_we"}, XLEN'(rf_we), XLEN'(exp_we));
    if (exp_we) begin
      chk({tag, " rf_addr"}, XLEN'(rf_addr), XLEN'(mq[0].a));
      chk({tag, " rf_data"}, rf_data, mq[0].d);
    end
    fwd_exp(v.fa1, eh, ed);
    chk({tag, " fwd_hit_1"}, XLEN'(fwd_hit_1), XLEN'(eh));
    chk({tag, " fwd_data_1"}, fwd_data_1, ed);
    fwd_exp(v.fa2, eh, ed);
    chk({tag, " fwd_hit_2"}, XLEN'(fwd_hit_2), XLEN'(eh));
    chk({tag, " fwd_data_2"}, fwd_data_2, ed);
    acc0 = v.p0v && (mq.size() <= DEPTH - 1);
    acc1 = v.p1v && (mq.size() <= DEPTH - 2);
    @(posedge clk);
    if (exp_we) void'(mq.pop_front());
    if (acc0 && v.p0a != 5'd0) mq.push_back('{a: v.p0a, d: v.p0d});
    if (acc1 && v.p1a != 5'd0) mq.push_back('{a: v.p1a, d: v.p1d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    p0_valid = 0; p0_addr = 0; p0_data = 0;
    p1_valid = 0; p1_addr = 0; p1_data = 0;
    rf_hold = 0; fwd_addr_1 = 5'd5; fwd_addr_2 = 5'd0;

    //            p0v p0a    p0d       p1v p1a    p1d     hold fa1    fa2    r0 r1
    vecs[0]  = mk(1, 5'd5, 64'h1234,  0, 5'd0, 64'h0,  0, 5'd5, 5'd0, 1, 1);
    vecs[1]  = mk(0, 5'd0, 64'h0,     0, 5'd0, 64'h0,  0, 5'd5, 5'd0, 1, 1);
    vecs[2]  = mk(0, 5'd0, 64'h0,     0, 5'd0, 64'h0,  0, 5'd5, 5'd0, 1, 1);
    vecs[3]  = mk(1, 5'd3, 64'hA,     1, 5'd3, 64'hB,  0, 5'd3, 5'd0, 1, 1);
    vecs[4]  = mk(0, 5'd0, 64'h0,     0, 5'd0, 64'h0,  0, 5'd3, 5'd3, 1, 1);
    vecs[5]  = mk(0, 5'd0, 64'h0,     0, 5'd0, 64'h0,  0, 5'd3, 5'd0, 1, 1);
    vecs[6]  = mk(1, 5'd0, 64'hFFFF,  0, 5'd0, 64'h0,  0, 5'd0, 5'd0, 1, 1);
    vecs[7]  = mk(0, 5'd0, 64'h0,     0, 5'd0, 64'h0,  0, 5'd0, 5'd0, 1, 1);
    vecs[8]  = mk(1, 5'd1, 64'h11,    0, 5'd0, 64'h0,  1, 5'd1, 5'd0, 1, 1);
    vecs[9]  = mk(1, 5'd2, 64'h22,    0, 5'd0, 64'h0,  1, 5'd1, 5'd2, 1, 1);
    vecs[10] = mk(1, 5'd1, 64'h33,    0, 5'd0, 64'h0,  1, 5'd1, 5'd2, 1, 1);
    vecs[11] = mk(1, 5'd4, 64'h44,    1, 5'd7, 64'h77, 1, 5'd1, 5'd7, 1, 0);
    vecs[12] = mk(1, 5'd6, 64'h66,    1, 5'd7, 64'h77, 1, 5'd1, 5'd4, 0, 0);
    vecs[13] = mk(1, 5'd6, 64'h66,    0, 5'd0, 64'h0,  0, 5'd1, 5'd6, 0, 0);
    vecs[14] = mk(0, 5'd0, 64'h0,     0, 5'd0, 64'h0,  0, 5'd1, 5'd2, 1, 0);
    vecs[15] = mk(0, 5'd0, 64'h0,     0, 5'd0, 64'h0,  0, 5'd1, 5'd4, 1, 1);
    vecs[16] = mk(0, 5'd0, 64'h0,     1, 5'd9, 64'h99, 0, 5'd4, 5'd9, 1, 1);
    vecs[17] = mk(0, 5'd0, 64'h0,     0, 5'd0, 64'h0,  0, 5'd9, 5'd0, 1, 1);

    // Reset state while rst is held.
    #1;
    chk("reset rf_we", XLEN'(rf_we), '0);
    chk("reset busy", XLEN'(busy), '0);
    chk("reset p0_ready", XLEN'(p0_ready), XLEN'(1));
    chk("reset p1_ready", XLEN'(p1_ready), XLEN'(1));
    chk("reset fwd_hit_1", XLEN'(fwd_hit_1), '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end
    chk("drain empty", XLEN'(mq.size()), '0);

    // Reset in the middle of a populated queue.
    step(mk(1, 5'd10, 64'hA0, 0, 5'd0, 64'h0, 1, 5'd10, 5'd0, 1, 1), "rstq0");
    step(mk(1, 5'd11, 64'hB0, 0, 5'd0, 64'h0, 1, 5'd10, 5'd0, 1, 1), "rstq1");
    step(mk(1, 5'd12, 64'hC0, 0, 5'd0, 64'h0, 1, 5'd11, 5'd0, 1, 1), "rstq2");
    @(negedge clk);
    p0_valid = 0; rf_hold = 0; fwd_addr_1 = 5'd10;
    #1;
    chk("pre-rst busy", XLEN'(busy), XLEN'(1));
    chk("pre-rst rf_we", XLEN'(rf_we), XLEN'(1));
    rst = 1'b1;
    #1;
    chk("async rst rf_we", XLEN'(rf_we), '0);
    chk("async rst busy", XLEN'(busy), '0);
    chk("async rst fwd_hit_1", XLEN'(fwd_hit_1), '0);
    chk("async rst p1_ready", XLEN'(p1_ready), XLEN'(1));
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(mk(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 5'd10, 5'd12, 1, 1), $sformatf("postrst%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
